// File: rtl/ram_port_ctrl.sv
// Single-master controller for a shared-bus RAM: valid/ready requests in, RAM address/isReading/tristate bus out.
// Optional write readback verify is compiled in with `define RAM_PORT_CTRL_READBACK_EN.
module ram_port_ctrl #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [0:DATA_WIDTH-1] req_wdata,
    output logic                  rsp_valid,
    output logic [0:DATA_WIDTH-1] rsp_rdata,
    output logic                  wr_done,
    output logic                  wr_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_isReading,
    inout  wire  [0:DATA_WIDTH-1] mem_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, VERIFY} state_e;

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    busy_q, busy_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [0:DATA_WIDTH-1]   rsp_rdata_q, rsp_rdata_d;
    logic                    wr_done_q, wr_done_d;
    logic                    wr_err_q, wr_err_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic                    mem_isReading_q, mem_isReading_d;
    logic                    oe_q, oe_d;
    logic [0:DATA_WIDTH-1]   dout_q, dout_d;

    // dout_q keeps the captured write data after the bus is released, so a verify can compare against it.
    assign mem_data      = oe_q ? dout_q : {DATA_WIDTH{1'bz}};
    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign wr_done       = wr_done_q;
    assign wr_err        = wr_err_q;
    assign mem_address   = mem_address_q;
    assign mem_isReading = mem_isReading_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        mem_address_d   = mem_address_q;
        mem_isReading_d = 1'b1;
        oe_d            = 1'b0;
        dout_d          = dout_q;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        wr_done_d       = 1'b0;
        wr_err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    mem_address_d = req_address;
                    if (req_write) begin
                        state_d         = WRITE;
                        mem_isReading_d = 1'b0;
                        oe_d            = 1'b1;
                        dout_d          = req_wdata;
                    end else begin
                        state_d = READ;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WRITE: begin
`ifdef RAM_PORT_CTRL_READBACK_EN
                state_d = VERIFY;
                cnt_d   = CNT_INIT;
`else
                state_d   = IDLE;
                wr_done_d = 1'b1;
`endif
            end
            READ: begin
                if (cnt_q == 2'd0) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_data;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
`ifdef RAM_PORT_CTRL_READBACK_EN
            VERIFY: begin
                if (cnt_q == 2'd0) begin
                    state_d   = IDLE;
                    wr_done_d = 1'b1;
                    wr_err_d  = (mem_data != dout_q);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= 2'd0;
            req_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            wr_done_q       <= 1'b0;
            wr_err_q        <= 1'b0;
            mem_address_q   <= '0;
            mem_isReading_q <= 1'b1;
            oe_q            <= 1'b0;
            dout_q          <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            busy_q          <= busy_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            wr_done_q       <= wr_done_d;
            wr_err_q        <= wr_err_d;
            mem_address_q   <= mem_address_d;
            mem_isReading_q <= mem_isReading_d;
            oe_q            <= oe_d;
            dout_q          <= dout_d;
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Scoreboard bench for ram_port_ctrl: driver pushes expectations from an array RAM model, a negedge monitor checks.
// Build with +define+RAM_PORT_CTRL_READBACK_EN to also exercise the readback verify path.
module tb_ram_port_ctrl;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int RL = 3;
`ifdef RAM_PORT_CTRL_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_address;
    logic [0:DW-1] req_wdata;
    logic          rsp_valid;
    logic [0:DW-1] rsp_rdata;
    logic          wr_done, wr_err, busy;
    logic [AW-1:0] mem_address;
    logic          mem_isReading;
    wire  [0:DW-1] mem_data;

    ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
        .mem_address(mem_address), .mem_isReading(mem_isReading), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // RAM model: not reset, stores on any rising edge with isReading low, drives the bus while reading.
    logic [0:DW-1] ram [2**AW];
    bit            corrupt = 1'b0;
    logic [0:DW-1] flip;
    assign flip     = corrupt ? 64'h1 : 64'h0;
    assign mem_data = mem_isReading ? (ram[mem_address] ^ flip) : {DW{1'bz}};

    initial begin
        for (int i = 0; i < 2**AW; i++) ram[i] = '0;
        ram[2047] = 64'h1;
        forever begin
            @(posedge clk);
            if (!mem_isReading) ram[mem_address] <= mem_data;
        end
    end

    typedef struct { logic [0:DW-1] data; int due; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic [0:DW-1] data; bit err; int acc; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    logic [0:DW-1] ref_mem [2**AW];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cycle);
    endtask

    // Monitor: compares every DUT response against the queued expectations.
    initial begin
        rsp_t r;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!mem_isReading) begin
                    chk("ready_low_in_write", req_ready, 1'b0);
                    if (wr_q.size() == 0) flag("unexpected_bus_write");
                    else begin
                        chk("write_addr", mem_address, wr_q[0].addr);
                        chk("write_bus", mem_data, wr_q[0].data);
                        chk("write_cycle", cycle, wr_q[0].acc);
                    end
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) flag("unexpected_rsp_valid");
                    else begin
                        r = rsp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.data);
                        chk("rsp_latency", cycle, r.due);
                        chk("ready_with_rsp", req_ready, 1'b1);
                    end
                end
                if (wr_done) begin
                    if (wr_q.size() == 0) flag("unexpected_wr_done");
                    else begin
                        w = wr_q.pop_front();
                        chk("wr_err", wr_err, w.err);
                        chk("wr_done_cycle", cycle, w.acc + 1 + RB * RL);
                    end
                end
                if (rsp_q.size() != 0 && rsp_q[0].due < cycle) begin
                    flag("rsp_missing");
                    void'(rsp_q.pop_front());
                end
                if (wr_q.size() != 0 && wr_q[0].acc + 1 + RB * RL < cycle) begin
                    flag("wr_done_missing");
                    void'(wr_q.pop_front());
                end
            end
        end
    end

    task automatic junk();
        req_valid   = 1'($urandom_range(0, 1));
        req_write   = 1'($urandom);
        req_address = AW'($urandom);
        req_wdata   = {$urandom, $urandom};
    endtask

    // Called at a negedge; presents the request once ready, returns at the negedge after the accept edge.
    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [0:DW-1] d,
                         input bit track, output int acc);
        int   guard = 0;
        rsp_t r;
        wr_t  e;
        while (!req_ready) begin
            junk();
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                flag("ready_timeout");
                break;
            end
        end
        req_valid   = 1'b1;
        req_write   = w;
        req_address = a;
        req_wdata   = d;
        acc = cycle + 1;
        if (track) begin
            if (w) begin
                ref_mem[a] = d;
                e.addr = a; e.data = d; e.err = (RB != 0) && corrupt; e.acc = acc;
                wr_q.push_back(e);
            end else begin
                r.data = ref_mem[a];
                r.due  = acc + RL;
                rsp_q.push_back(r);
            end
        end
        @(negedge clk);
        junk();
    endtask

    task automatic drain();
        int g = 0;
        req_valid = 1'b0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) flag("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        int a0, a1;
        logic [AW-1:0] ad;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        ref_mem[2047] = 64'h1;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_wr_done", wr_done, 1'b0);
        chk("rst_wr_err", wr_err, 1'b0);
        chk("rst_mem_address", mem_address, 11'd0);
        chk("rst_mem_isReading", mem_isReading, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b1, 11'd1024, 64'h000000000000ff04, 1'b1, a0);
        drain();
        issue(1'b0, 11'd1023, '0, 1'b1, a0);
        issue(1'b0, 11'd1024, '0, 1'b1, a1);
        chk("read_read_gap", a1 - a0, RL + 1);
        drain();

        issue(1'b1, 11'd0, 64'hAAAA_5555_0000_FFFF, 1'b1, a0);
        issue(1'b0, 11'd2047, '0, 1'b1, a1);
        chk("write_read_gap", a1 - a0, 2 + RB * RL);
        drain();

        // Reset in the second READ cycle abandons the read.
        issue(1'b0, 11'd1024, '0, 1'b0, a0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_rdata", rsp_rdata, 64'h0);
        chk("midrst_isReading", mem_isReading, 1'b1);
        reset = 1'b0;
        repeat (RL + 2) @(negedge clk);

`ifdef RAM_PORT_CTRL_READBACK_EN
        issue(1'b1, 11'd5, 64'h1234, 1'b1, a0);
        drain();
        corrupt = 1'b1;
        issue(1'b1, 11'd5, 64'h5678, 1'b1, a0);
        drain();
        corrupt = 1'b0;
`endif

        repeat (300) begin
            case ($urandom_range(0, 9))
                0:       ad = 11'd0;
                1:       ad = 11'd2047;
                default: ad = AW'(1020 + $urandom_range(0, 15));
            endcase
            issue(1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, 1'b1, a0);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();
        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
- Single-master controller for the 2048 x 64 shared-bus RAM (11-bit address, isReading select, bidirectional 64-bit data bus).
- Accepts read/write requests over a valid/ready handshake, sequences RAM address, isReading and tristate bus drive, and returns read data with a one-cycle response pulse.
- Sits directly upstream of the RAM. It is the only agent permitted to drive the RAM data bus.

Parameters:
- ADDR_WIDTH, 11, RAM word-address width.
- DATA_WIDTH, 64, data width. Buses are declared [0:DATA_WIDTH-1], with bit 0 as MSB.
- READ_LATENCY, 1, cycles the address is held with isReading=1 before data is sampled. Legal range 1..4.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDR_WIDTH  target word.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  DATA_WIDTH  captured read data.
- wr_done  out  1  one-cycle pulse; the write has completed.
- wr_err  out  1  readback mismatch. Qualified by wr_done.
- busy  out  1  state is not IDLE.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_isReading  out  1  to RAM isReading.
- mem_data  inout  DATA_WIDTH  RAM shared data bus.

Behaviour:
- All outputs are registered except mem_data, which is driven from a registered value and a registered output-enable.
- Reset state:
  - state=IDLE
  - req_ready=1, busy=0
  - rsp_valid=0, rsp_rdata=0
  - wr_done=0, wr_err=0
  - mem_address=0, mem_isReading=1
  - mem_data released (all Z)
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - The controller captures req_* at acceptance. The requester may change them afterwards.
- State machine: IDLE, WRITE, READ, VERIFY (VERIFY exists only with the optional feature).
- IDLE:
  - mem_isReading=1 and bus released.
  - mem_address holds its last value.
  - Accepted write goes to WRITE. Accepted read goes to READ.
- WRITE (exactly 1 cycle):
  - mem_address=captured address, mem_isReading=0, mem_data driven with captured wdata.
  - The RAM stores the word on the rising edge that ends this cycle.
  - At that same edge: return to IDLE, release the bus, set mem_isReading=1, pulse wr_done with wr_err=0.
- READ (READ_LATENCY cycles):
  - mem_address=captured address, mem_isReading=1, bus released.
  - A down-counter runs from READ_LATENCY-1 to 0.
  - On the edge where the counter reads 0: rsp_rdata <= mem_data, rsp_valid <= 1, state <= IDLE.
  - rsp_valid and req_ready=1 therefore coincide.
- Throughput and latency:
  - Back-to-back requests: write every 2 cycles, read every READ_LATENCY+1 cycles.
  - Read latency from accept edge to rsp_valid high: READ_LATENCY edges.
- rsp_rdata holds its value until the next read captures.
- The bus is never driven while mem_isReading=1. The bus enable is asserted only in WRITE.
- Request inputs are ignored while not ready. Requests are never queued or dropped silently; the requester holds req_valid.
- Reset mid-operation:
  - All state returns to reset values at the reset edge. The in-flight request is abandoned: no rsp_valid, no wr_done.
  - A write whose WRITE cycle ends on the reset edge still lands in the RAM, because the RAM is not reset.
- Address wrap: none. Every address 0..2^ADDR_WIDTH-1 is legal, including 0 and 2047.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: RAM_PORT_CTRL_READBACK_EN.
- With the macro:
  - WRITE goes to VERIFY instead of IDLE.
  - VERIFY holds the same address with mem_isReading=1 and the bus released for READ_LATENCY cycles.
  - On the final edge it compares mem_data to the captured wdata, pulses wr_done, sets wr_err=(mismatch), and returns to IDLE.
  - A write then occupies 1+READ_LATENCY cycles. rsp_valid is not pulsed for a verify.
- Without the macro:
  - VERIFY logic is not compiled.
  - wr_done pulses at the end of WRITE.
  - wr_err is constant 0.

Test Plan:
- Reset with all inputs 0 -> mem_isReading=1, mem_data=Z, req_ready=1, rsp_valid=0, mem_address=0.
- Write 0xff04 to 1024 -> one cycle with mem_address=1024, mem_isReading=0, mem_data=0x000000000000ff04; wr_done pulse follows; bus Z afterwards.
- Read 1023 (preloaded 0x0) then read 1024 -> rsp_valid pulses after READ_LATENCY edges with rsp_rdata=0x0, then 0xff04; no bus drive during either read.
- Write 0xAAAA_5555_0000_FFFF to 0 then immediately read 2047 (preloaded 0x1) -> second accept exactly 2 cycles after the first; rsp_rdata=0x1; req_ready low during WRITE.
- Assert reset during READ (READ_LATENCY=3, second cycle) -> no rsp_valid, state IDLE, req_ready=1 next cycle, rsp_rdata=0.
- With RAM_PORT_CTRL_READBACK_EN: write 0x1234 to 5 -> wr_done with wr_err=0; force the RAM model to corrupt bit 63 -> wr_err=1 on wr_done.
